// File: rtl/bm_dag2_chk.sv
// rtl/bm_dag2_chk.sv - two-stage checker for a (a+b), (t1-b), (t1+t2) reference DAG
// Accepts (a, b, dut_out) triples in RUN, counts checks and failures, captures the first failure.
module bm_dag2_chk #(
  parameter int BITS  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             halt_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  a_in,
  input  logic [BITS-1:0]  b_in,
  input  logic [BITS-1:0]  dut_out,
  output logic             mismatch,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_valid,
  output logic [BITS-1:0]  err_a,
  output logic [BITS-1:0]  err_b,
  output logic [BITS-1:0]  err_got,
  output logic [BITS-1:0]  err_exp,
  output logic             halted,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_q, state_d;

  logic            v1_q, v1_d;
  logic [BITS-1:0] a1_q, a1_d, b1_q, b1_d, o1_q, o1_d, t1_q, t1_d;

  logic            v2_q, v2_d;
  logic            fail2_q, fail2_d;
  logic [BITS-1:0] a2_q, a2_d, b2_q, b2_d, o2_q, o2_d, exp2_q, exp2_d;

  logic [CNT_W-1:0] chk_q, chk_d, err_q, err_d;
  logic             errv_q, errv_d;
  logic [BITS-1:0]  ea_q, ea_d, eb_q, eb_d, eg_q, eg_d, ee_q, ee_d;
  logic             mis_q, mis_d;

  logic            accept;
  logic            start_go;
  logic            rec;
  logic            rec_fail;
  logic [BITS-1:0] temp2;

  // A session restart wins over a result leaving stage 2 in the same cycle.
  assign accept   = in_valid && (state_q == S_RUN);
  assign start_go = start && (state_q != S_RUN);
  assign rec      = v2_q && !start_go;
  assign rec_fail = rec && fail2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      o1_q    <= '0;
      t1_q    <= '0;
      v2_q    <= 1'b0;
      fail2_q <= 1'b0;
      a2_q    <= '0;
      b2_q    <= '0;
      o2_q    <= '0;
      exp2_q  <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      errv_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      eg_q    <= '0;
      ee_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      o1_q    <= o1_d;
      t1_q    <= t1_d;
      v2_q    <= v2_d;
      fail2_q <= fail2_d;
      a2_q    <= a2_d;
      b2_q    <= b2_d;
      o2_q    <= o2_d;
      exp2_q  <= exp2_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      errv_q  <= errv_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      eg_q    <= eg_d;
      ee_q    <= ee_d;
      mis_q   <= mis_d;
    end
  end

  // A recorded failure with halt_en set takes precedence over stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (rec_fail && halt_en) state_d = S_HALT;
        else if (stop)           state_d = S_IDLE;
      end
      S_HALT: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_RUN);
    halted   = (state_q == S_HALT);
    busy     = (state_q != S_IDLE) || v1_q || v2_q;
  end

  always_comb begin
    v1_d = accept;
    a1_d = a1_q;
    b1_d = b1_q;
    o1_d = o1_q;
    t1_d = t1_q;
    if (accept) begin
      a1_d = a_in;
      b1_d = b_in;
      o1_d = dut_out;
      t1_d = a_in + b_in;
    end
  end

  always_comb begin
    temp2   = t1_q - b1_q;
    v2_d    = v1_q;
    a2_d    = a2_q;
    b2_d    = b2_q;
    o2_d    = o2_q;
    exp2_d  = exp2_q;
    fail2_d = fail2_q;
    if (v1_q) begin
      a2_d    = a1_q;
      b2_d    = b1_q;
      o2_d    = o1_q;
      exp2_d  = t1_q + temp2;
      fail2_d = (o1_q != (t1_q + temp2));
    end
  end

  always_comb begin
    chk_d  = chk_q;
    err_d  = err_q;
    errv_d = errv_q;
    ea_d   = ea_q;
    eb_d   = eb_q;
    eg_d   = eg_q;
    ee_d   = ee_q;
    mis_d  = rec_fail;
    if (start_go) begin
      chk_d  = '0;
      err_d  = '0;
      errv_d = 1'b0;
      ea_d   = '0;
      eb_d   = '0;
      eg_d   = '0;
      ee_d   = '0;
    end else if (rec) begin
      if (chk_q != CNT_MAX) chk_d = chk_q + 1'b1;
      if (fail2_q) begin
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        if (!errv_q) begin
          errv_d = 1'b1;
          ea_d   = a2_q;
          eb_d   = b2_q;
          eg_d   = o2_q;
          ee_d   = exp2_q;
        end
      end
    end
  end

  assign mismatch  = mis_q;
  assign chk_count = chk_q;
  assign err_count = err_q;
  assign err_valid = errv_q;
  assign err_a     = ea_q;
  assign err_b     = eb_q;
  assign err_got   = eg_q;
  assign err_exp   = ee_q;

endmodule

// File: tb/tb_bm_dag2_chk.sv
// tb/tb_bm_dag2_chk.sv - scoreboard bench for bm_dag2_chk (CNT_W=8 and CNT_W=2 instances)
module tb_bm_dag2_chk;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, halt_en = 1'b0, in_valid = 1'b0;
  logic [1:0] a_in = '0, b_in = '0, dut_out = '0;

  logic       in_ready, mismatch, err_valid, halted, busy;
  logic [7:0] chk_count, err_count;
  logic [1:0] err_a, err_b, err_got, err_exp;

  logic       in_ready_s, mismatch_s, err_valid_s, halted_s, busy_s;
  logic [1:0] chk_count_s, err_count_s;
  logic [1:0] err_a_s, err_b_s, err_got_s, err_exp_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  bm_dag2_chk #(.BITS(2), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .halt_en(halt_en),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .dut_out(dut_out),
    .mismatch(mismatch), .chk_count(chk_count), .err_count(err_count), .err_valid(err_valid),
    .err_a(err_a), .err_b(err_b), .err_got(err_got), .err_exp(err_exp),
    .halted(halted), .busy(busy)
  );

  bm_dag2_chk #(.BITS(2), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .halt_en(halt_en),
    .in_valid(in_valid), .in_ready(in_ready_s), .a_in(a_in), .b_in(b_in), .dut_out(dut_out),
    .mismatch(mismatch_s), .chk_count(chk_count_s), .err_count(err_count_s), .err_valid(err_valid_s),
    .err_a(err_a_s), .err_b(err_b_s), .err_got(err_got_s), .err_exp(err_exp_s),
    .halted(halted_s), .busy(busy_s)
  );

  typedef struct {
    logic       in_ready, mismatch, err_valid, halted, busy;
    int         chk, err;
    logic [1:0] ea, eb, eg, ee;
  } snap_t;

  typedef struct {
    int         due;
    logic [1:0] a, b, o;
  } item_t;

  snap_t exp_q[$];
  item_t pipe_q[$];

  // Reference model: whole-session bookkeeping with unbounded counts; saturation applied at compare time.
  int         m_state = 0;  // 0 idle, 1 run, 2 halt
  int         n_chk = 0, n_err = 0;
  logic       m_ev = 1'b0, m_mis;
  logic [1:0] m_ea = '0, m_eb = '0, m_eg = '0, m_ee = '0;

  always @(posedge clock) begin : model
    item_t      it;
    item_t      nw;
    bit         have;
    logic [1:0] expv;
    snap_t      s;
    cyc   = cyc + 1;
    have  = 1'b0;
    m_mis = 1'b0;
    if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
      it   = pipe_q.pop_front();
      have = 1'b1;
    end
    if (reset) begin
      m_state = 0; n_chk = 0; n_err = 0; m_ev = 1'b0;
      m_ea = '0; m_eb = '0; m_eg = '0; m_ee = '0;
      pipe_q.delete();
    end else begin
      if (in_valid && m_state == 1) begin
        nw.due = cyc + 2; nw.a = a_in; nw.b = b_in; nw.o = dut_out;
        pipe_q.push_back(nw);
      end
      if (start && m_state != 1) begin
        m_state = 1; n_chk = 0; n_err = 0; m_ev = 1'b0;
        m_ea = '0; m_eb = '0; m_eg = '0; m_ee = '0;
      end else begin
        if (have) begin
          expv  = 2'((2 * int'(it.a) + int'(it.b)) % 4);
          n_chk = n_chk + 1;
          if (it.o != expv) begin
            n_err = n_err + 1;
            m_mis = 1'b1;
            if (!m_ev) begin
              m_ev = 1'b1; m_ea = it.a; m_eb = it.b; m_eg = it.o; m_ee = expv;
            end
            if (halt_en && m_state == 1) m_state = 2;
          end
        end
        if (stop && m_state == 1) m_state = 0;
      end
    end
    s.in_ready  = (m_state == 1);
    s.halted    = (m_state == 2);
    s.busy      = (m_state != 0) || (pipe_q.size() > 0);
    s.mismatch  = m_mis;
    s.err_valid = m_ev;
    s.chk = n_chk; s.err = n_err;
    s.ea = m_ea; s.eb = m_eb; s.eg = m_eg; s.ee = m_ee;
    exp_q.push_back(s);
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clock) begin : monitor
    snap_t s;
    bit    bad;
    if (exp_q.size() > 0) begin
      s     = exp_q.pop_front();
      tests = tests + 1;
      bad = (in_ready !== s.in_ready) || (mismatch !== s.mismatch) || (err_valid !== s.err_valid) ||
            (halted !== s.halted) || (busy !== s.busy) ||
            (int'(chk_count) != sat(s.chk, 255)) || (int'(err_count) != sat(s.err, 255)) ||
            (err_a !== s.ea) || (err_b !== s.eb) || (err_got !== s.eg) || (err_exp !== s.ee) ||
            (int'(chk_count_s) != sat(s.chk, 3)) || (int'(err_count_s) != sat(s.err, 3)) ||
            (mismatch_s !== s.mismatch) || (halted_s !== s.halted) || (err_valid_s !== s.err_valid);
      if (bad) begin
        fails = fails + 1;
        $display("FAIL snapshot cyc=%0d got rdy=%b mis=%b ev=%b halt=%b busy=%b chk=%0d err=%0d e=%0d/%0d/%0d/%0d chk2=%0d err2=%0d | exp rdy=%b mis=%b ev=%b halt=%b busy=%b chk=%0d err=%0d e=%0d/%0d/%0d/%0d chk2=%0d err2=%0d",
                 cyc, in_ready, mismatch, err_valid, halted, busy, chk_count, err_count,
                 err_a, err_b, err_got, err_exp, chk_count_s, err_count_s,
                 s.in_ready, s.mismatch, s.err_valid, s.halted, s.busy, sat(s.chk, 255), sat(s.err, 255),
                 s.ea, s.eb, s.eg, s.ee, sat(s.chk, 3), sat(s.err, 3));
      end
    end
  end

  task automatic drv(input bit r, input bit st, input bit sp, input bit he, input bit v,
                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] o);
    @(negedge clock);
    reset = r; start = st; stop = sp; halt_en = he; in_valid = v;
    a_in = a; b_in = b; dut_out = o;
  endtask

  task automatic idle(input int n, input bit he);
    repeat (n) drv(1'b0, 1'b0, 1'b0, he, 1'b0, 2'd0, 2'd0, 2'd0);
  endtask

  task automatic trip(input bit he, input logic [1:0] a, input logic [1:0] b, input logic [1:0] o);
    drv(1'b0, 1'b0, 1'b0, he, 1'b1, a, b, o);
  endtask

  initial begin
    logic [1:0] ra, rb, ro;
    bit         he;
    repeat (2) drv(1'b1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);

    // Three good triples back to back.
    drv(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    trip(0, 2'd1, 2'd2, 2'd0);
    trip(0, 2'd3, 2'd3, 2'd1);
    trip(0, 2'd2, 2'd1, 2'd1);
    idle(3, 0);

    // Single failing triple with first-error capture.
    drv(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0);
    drv(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    trip(0, 2'd1, 2'd2, 2'd3);
    idle(3, 0);

    // Halt on second triple; third drains, fourth is refused.
    drv(0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0);
    drv(0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0);
    trip(1, 2'd0, 2'd0, 2'd0);
    trip(1, 2'd1, 2'd1, 2'd0);
    trip(1, 2'd2, 2'd2, 2'd2);
    idle(1, 1);
    trip(1, 2'd3, 2'd0, 2'd2);
    idle(3, 1);

    // Restart from HALT.
    drv(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    trip(0, 2'd1, 2'd2, 2'd0);
    idle(3, 0);

    // Five failures saturate the narrow counters.
    drv(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0);
    drv(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    repeat (5) trip(0, 2'd1, 2'd2, 2'd3);
    idle(3, 0);

    // Start colliding with a draining result.
    drv(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0);
    drv(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    trip(0, 2'd1, 2'd2, 2'd3);
    drv(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0);
    drv(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    idle(3, 0);

    // Reset with both stages occupied.
    trip(0, 2'd1, 2'd2, 2'd3);
    trip(0, 2'd2, 2'd2, 2'd1);
    drv(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    idle(3, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      ro = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'((2 * int'(ra) + int'(rb)) % 4);
      he = 1'($urandom_range(0, 1));
      drv(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
          he, ($urandom_range(0, 3) != 0), ra, rb, ro);
    end
    idle(5, 0);
    @(negedge clock);
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bm_dag2_chk.md
BM_DAG2_CHK -- requirements
Module: bm_dag2_chk

Interface
REQ-001 Parameter BITS, default 2, operand/result width.
REQ-002 Parameter CNT_W, default 8, counter width.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  begin checking session; acted on only in IDLE or HALT.
REQ-006 Port stop  input  1  end session; acted on only in RUN.
REQ-007 Port halt_en  input  1  when high, first mismatch forces HALT.
REQ-008 Port in_valid  input  1  triple (a_in, b_in, dut_out) presented.
REQ-009 Port in_ready  output  1  checker accepts triple this cycle.
REQ-010 Port a_in  input  BITS  operand a applied to the DUT.
REQ-011 Port b_in  input  BITS  operand b applied to the DUT.
REQ-012 Port dut_out  input  BITS  DUT result to be checked.
REQ-013 Port mismatch  output  1  one-cycle pulse per failing triple.
REQ-014 Port chk_count  output  CNT_W  triples checked this session.
REQ-015 Port err_count  output  CNT_W  failing triples this session.
REQ-016 Port err_valid  output  1  first-error capture registers hold data.
REQ-017 Port err_a, err_b, err_got, err_exp  output  BITS each  operands, DUT value, expected value of first failing triple.
REQ-018 Port halted  output  1  high while in HALT.
REQ-019 Port busy  output  1  high when state is not IDLE or any pipeline stage is valid.

Function
REQ-020 States SHALL be IDLE, RUN, HALT; in_ready SHALL equal (state == RUN).
REQ-021 IDLE -> RUN, and HALT -> RUN, on start; this edge SHALL clear chk_count, err_count, err_valid and err_* to 0.
REQ-022 RUN -> IDLE on stop; start SHALL be ignored in RUN; stop SHALL be ignored in IDLE and HALT.
REQ-023 A triple SHALL be accepted at edge E iff in_valid and in_ready are both high at E; no other triple is consumed.
REQ-024 Stage 1 SHALL register at E: a, b, dut_out, temp1 = (a + b) mod 2^BITS, valid1.
REQ-025 Stage 2 SHALL register at E+1: temp2 = (temp1 - b) mod 2^BITS, exp = (temp1 + temp2) mod 2^BITS, fail = (dut_out != exp), valid2.
REQ-026 At edge E+2, for valid2: chk_count SHALL increment; if fail, err_count SHALL increment and mismatch SHALL be high for that one cycle; otherwise mismatch SHALL be low.
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 On the first fail of a session, err_valid SHALL set and err_* SHALL load; later fails SHALL NOT modify err_*.
REQ-029 If halt_en is high when a fail is recorded in RUN, state SHALL go to HALT at that edge; any stop at that edge is overridden.
REQ-030 Triples already in the pipeline SHALL drain and be counted in every state, including IDLE and HALT.
REQ-031 Back-to-back acceptance SHALL sustain one triple per cycle; no bubble is required.
REQ-032 start in the same cycle as a counter update SHALL give the clear priority; the drained result is discarded.

Reset
REQ-033 Reset SHALL force IDLE, clear valid1 and valid2, and drive in_ready, mismatch, halted, err_valid, chk_count, err_count and err_* to 0, overriding all other inputs including mid-session and mid-pipeline.

Verification
REQ-034 BITS=2: start, then triples (a=1, b=2, out=0), (3, 3, 1), (2, 1, 1) on consecutive cycles -> chk_count=3, err_count=0, mismatch never high.
REQ-035 Triple (a=1, b=2, out=3), accepted at edge E -> mismatch high after E+2 only, err_a=1, err_b=2, err_got=3, err_exp=0, err_valid=1.
REQ-036 halt_en=1; stream of 4 triples, 2nd wrong -> HALT at its E+2 and in_ready=0; 3rd (already in flight) still counted; chk_count=3, halted=1.
REQ-037 CNT_W=2; 5 failing triples -> err_count and chk_count hold at 3.
REQ-038 Reset asserted with both stages valid -> next cycle: IDLE, busy=0, all counters and err_* at 0, no mismatch pulse.
REQ-039 HALT, then start -> RUN with counters and err_valid cleared; the next good triple gives chk_count=1.
